// File: rtl/hex_message_scroller_pkg.sv
// hex_msg_pkg: shared definitions for hex_message_scroller.
//   - 5-bit character codes understood by the downstream seven-segment decoders
//   - game_state_t / scroll_state_t enums
//   - banner ROM text constants, banner lengths and small helper functions
// Optional feature macro: SCORE_TAIL_EN (appends dash + 3 score digits to every banner).
package hex_msg_pkg;

  typedef enum logic [1:0] {
    GS_PLAY     = 2'b00,
    GS_WIN      = 2'b01,
    GS_LOSE     = 2'b10,
    GS_GAMEOVER = 2'b11
  } game_state_t;

  typedef enum logic {
    SHOW_PLAY = 1'b0,
    SCROLL    = 1'b1
  } scroll_state_t;

  localparam logic [4:0] CODE_A     = 5'h0A;
  localparam logic [4:0] CODE_C     = 5'h0C;
  localparam logic [4:0] CODE_E     = 5'h0E;
  localparam logic [4:0] CODE_G     = 5'h10;
  localparam logic [4:0] CODE_L     = 5'h13;
  localparam logic [4:0] CODE_M     = 5'h14;
  localparam logic [4:0] CODE_O     = 5'h16;
  localparam logic [4:0] CODE_R     = 5'h19;
  localparam logic [4:0] CODE_S     = 5'h1A;
  localparam logic [4:0] CODE_V     = 5'h1D;
  localparam logic [4:0] CODE_BLANK = 5'h1E;
  localparam logic [4:0] CODE_DASH  = 5'h1F;

  localparam int LEAD_BLANKS = 6;
`ifdef SCORE_TAIL_EN
  localparam int TAIL_LEN = 4;
`else
  localparam int TAIL_LEN = 0;
`endif

  localparam int WIN_TEXT_LEN  = 5;
  localparam int LOSE_TEXT_LEN = 4;
  localparam int GO_TEXT_LEN   = 8;
  localparam int WIN_LEN  = LEAD_BLANKS + WIN_TEXT_LEN + TAIL_LEN;
  localparam int LOSE_LEN = LEAD_BLANKS + LOSE_TEXT_LEN + TAIL_LEN;
  localparam int GO_LEN   = LEAD_BLANKS + GO_TEXT_LEN + TAIL_LEN;
  localparam int POS_W    = $clog2(GO_LEN + 1);

  // Text ROMs, first character in the most significant 5 bits, blank padded.
  localparam logic [39:0] WIN_TEXT  = {CODE_C, CODE_L, CODE_E, CODE_A, CODE_R, {3{CODE_BLANK}}};
  localparam logic [39:0] LOSE_TEXT = {CODE_L, CODE_O, CODE_S, CODE_E, {4{CODE_BLANK}}};
  localparam logic [39:0] GO_TEXT   = {CODE_G, CODE_A, CODE_M, CODE_E, CODE_O, CODE_V, CODE_E, CODE_R};

  // Shift-add-3 digit correction.
  function automatic logic [3:0] bcd_adj(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  function automatic logic [POS_W-1:0] text_len(input game_state_t gs);
    case (gs)
      GS_WIN:      return POS_W'(WIN_TEXT_LEN);
      GS_LOSE:     return POS_W'(LOSE_TEXT_LEN);
      GS_GAMEOVER: return POS_W'(GO_TEXT_LEN);
      default:     return POS_W'(WIN_TEXT_LEN);
    endcase
  endfunction

  function automatic logic [POS_W-1:0] banner_len(input game_state_t gs);
    return text_len(gs) + POS_W'(LEAD_BLANKS + TAIL_LEN);
  endfunction

  function automatic logic [4:0] text_char(input game_state_t gs, input logic [POS_W-1:0] t);
    logic [39:0] txt;
    logic [4:0]  c;
    case (gs)
      GS_WIN:      txt = WIN_TEXT;
      GS_LOSE:     txt = LOSE_TEXT;
      GS_GAMEOVER: txt = GO_TEXT;
      default:     txt = {8{CODE_BLANK}};
    endcase
    c = CODE_BLANK;
    for (int i = 0; i < 8; i++) begin
      c = (t == POS_W'(i)) ? txt[39-5*i -: 5] : c;
    end
    return c;
  endfunction

endpackage

// File: rtl/hex_message_scroller_if.sv
// hex_message_scroller_if: game-side inputs and display-side outputs of the scroller.
//   game_state [1:0]      : 00 PLAY, 01 WIN, 10 LOSE, 11 GAMEOVER
//   lives [2:0]           : remaining lives
//   score [SCORE_W-1:0]   : binary score
//   codes [29:0]          : character codes, [4:0] = HEX0 ... [29:25] = HEX5
//   bcd_busy              : score conversion in progress
// master = game logic / bench, slave = hex_message_scroller.
interface hex_message_scroller_if #(parameter int SCORE_W = 10);
  logic [1:0]         game_state;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [29:0]        codes;
  logic               bcd_busy;

  modport master (output game_state, lives, score, input codes, bcd_busy);
  modport slave  (input game_state, lives, score, output codes, bcd_busy);
endinterface

// File: rtl/hex_message_scroller_bin2bcd.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one input bit per cycle.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load bin and begin (ignored while busy)
//   bin        : binary value, must be <= 999
//   busy       : registered, high for exactly SCORE_W cycles after start
//   done       : high in the final conversion cycle; hund/tens/ones valid then
//   hund/tens/ones : BCD result (meaningful only while done is high)
module bin2bcd_seq
  import hex_msg_pkg::*;
#(
  parameter int SCORE_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [3:0]         hund,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);
  localparam int CNT_W = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] shift_r;
  logic [11:0]        acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [11:0]        acc_next_s;

  // correct each digit then shift the next input bit into the accumulator
  always_comb begin
    acc_next_s = {bcd_adj(acc_r[11:8]), bcd_adj(acc_r[7:4]), bcd_adj(acc_r[3:0])};
    acc_next_s = {acc_next_s[10:0], shift_r[SCORE_W-1]};
    if (busy && (cnt_r == CNT_W'(1))) begin
      done = 1'b1;
    end else begin
      done = 1'b0;
    end
    hund = acc_next_s[11:8];
    tens = acc_next_s[7:4];
    ones = acc_next_s[3:0];
  end

  // conversion sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= {SCORE_W{1'b0}};
      acc_r   <= 12'd0;
      cnt_r   <= {CNT_W{1'b0}};
      busy    <= 1'b0;
    end else if (busy) begin
      shift_r <= {shift_r[SCORE_W-2:0], 1'b0};
      acc_r   <= acc_next_s;
      cnt_r   <= cnt_r - CNT_W'(1);
      busy    <= (cnt_r != CNT_W'(1));
    end else if (start) begin
      shift_r <= bin;
      acc_r   <= 12'd0;
      cnt_r   <= CNT_W'(SCORE_W);
      busy    <= 1'b1;
    end else begin
      busy    <= 1'b0;
    end
  end
endmodule

// File: rtl/hex_message_scroller.sv
// hex_message_scroller: drives the six HEX character codes.
//   PLAY: lives, dash, blank, 3-digit decimal score. Other states: scrolling banner.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : hex_message_scroller_if.slave (game_state, lives, score in; codes, bcd_busy out)
// Parameters: SCROLL_DIV (cycles per scroll step, >= 2), SCORE_W (score width, >= 10).
// Optional feature macro: SCORE_TAIL_EN appends dash,hund,tens,ones to each banner.
module hex_message_scroller
  import hex_msg_pkg::*;
#(
  parameter int SCROLL_DIV = 12_500_000,
  parameter int SCORE_W    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  hex_message_scroller_if.slave  bus
);
  localparam int PRESC_W = $clog2(SCROLL_DIV);

  logic [SCORE_W-1:0] score_sat_s;
  logic [SCORE_W-1:0] latched_r;
  logic               start_s;
  logic               conv_busy_s;
  logic               conv_done_s;
  logic [3:0]         conv_h_s, conv_t_s, conv_o_s;
  logic [3:0]         hund_r, tens_r, ones_r;

  scroll_state_t      state_r;
  game_state_t        gs_r;
  game_state_t        gs_in_s;
  logic [POS_W-1:0]   p_r;
  logic [PRESC_W-1:0] presc_r;
  logic [29:0]        codes_r;
  logic [29:0]        play_s;
  logic [29:0]        window_s;
  logic [POS_W-1:0]   len_s;
  logic [POS_W:0]     sum_s;

  function automatic logic [4:0] banner_char(input game_state_t gs, input logic [POS_W-1:0] idx,
                                             input logic [3:0] h, input logic [3:0] t,
                                             input logic [3:0] o);
    logic [POS_W-1:0] k;
    logic [4:0]       c;
    c = CODE_BLANK;
    k = idx - POS_W'(LEAD_BLANKS);
    if (idx < POS_W'(LEAD_BLANKS)) begin
      c = CODE_BLANK;
    end else if (k < text_len(gs)) begin
      c = text_char(gs, k);
    end else begin
`ifdef SCORE_TAIL_EN
      k = k - text_len(gs);
      if (k == POS_W'(0))      c = CODE_DASH;
      else if (k == POS_W'(1)) c = {1'b0, h};
      else if (k == POS_W'(2)) c = {1'b0, t};
      else if (k == POS_W'(3)) c = {1'b0, o};
      else                     c = CODE_BLANK;
`else
      c = CODE_BLANK;
`endif
    end
    return c;
  endfunction

  // saturate the score and decide whether a new conversion should start
  always_comb begin
    gs_in_s = game_state_t'(bus.game_state);
    if (bus.score > SCORE_W'(999)) begin
      score_sat_s = SCORE_W'(999);
    end else begin
      score_sat_s = bus.score;
    end
    start_s = (score_sat_s != latched_r) && !conv_busy_s;
  end

  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_s),
    .bin   (score_sat_s),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .hund  (conv_h_s),
    .tens  (conv_t_s),
    .ones  (conv_o_s)
  );

  // latched score and held display digits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latched_r <= {SCORE_W{1'b0}};
      hund_r    <= 4'd0;
      tens_r    <= 4'd0;
      ones_r    <= 4'd0;
    end else begin
      if (start_s) latched_r <= score_sat_s;
      else         latched_r <= latched_r;
      if (conv_done_s) begin
        hund_r <= conv_h_s;
        tens_r <= conv_t_s;
        ones_r <= conv_o_s;
      end else begin
        hund_r <= hund_r;
      end
    end
  end

  // PLAY layout and the six-character banner window starting at p
  always_comb begin
    play_s   = {2'b00, bus.lives, CODE_DASH, CODE_BLANK,
                1'b0, hund_r, 1'b0, tens_r, 1'b0, ones_r};
    window_s = {6{CODE_BLANK}};
    len_s    = banner_len(gs_r);
    sum_s    = {(POS_W+1){1'b0}};
    for (int k = 0; k < 6; k++) begin
      sum_s = {1'b0, p_r} + (POS_W+1)'(k);
      if (sum_s >= {1'b0, len_s}) sum_s = sum_s - {1'b0, len_s};
      else                        sum_s = sum_s;
      window_s[(5-k)*5 +: 5] = banner_char(gs_r, sum_s[POS_W-1:0], hund_r, tens_r, ones_r);
    end
  end

  // scroll state machine with registered display codes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= SHOW_PLAY;
      gs_r    <= GS_PLAY;
      p_r     <= {POS_W{1'b0}};
      presc_r <= {PRESC_W{1'b0}};
      codes_r <= {6{CODE_BLANK}};
    end else begin
      case (state_r)
        SHOW_PLAY: codes_r <= play_s;
        SCROLL:    codes_r <= window_s;
        default:   codes_r <= {6{CODE_BLANK}};
      endcase
      // a state change has priority over a coincident prescaler terminal count
      if (gs_in_s != gs_r) begin
        gs_r    <= gs_in_s;
        p_r     <= {POS_W{1'b0}};
        presc_r <= {PRESC_W{1'b0}};
        state_r <= (gs_in_s == GS_PLAY) ? SHOW_PLAY : SCROLL;
      end else begin
        case (state_r)
          SCROLL: begin
            if (presc_r == PRESC_W'(SCROLL_DIV - 1)) begin
              presc_r <= {PRESC_W{1'b0}};
              p_r     <= (p_r >= len_s - POS_W'(1)) ? {POS_W{1'b0}} : (p_r + POS_W'(1));
            end else begin
              presc_r <= presc_r + PRESC_W'(1);
            end
          end
          SHOW_PLAY: begin
            presc_r <= {PRESC_W{1'b0}};
            p_r     <= {POS_W{1'b0}};
          end
          default: state_r <= SHOW_PLAY;
        endcase
      end
    end
  end

  assign bus.codes    = codes_r;
  assign bus.bcd_busy = conv_busy_s;
endmodule

// File: tb/tb_hex_message_scroller.sv
// Self-checking bench for hex_message_scroller (SCROLL_DIV = 4, SCORE_W = 10).
// A timing-level model (elapsed cycles since the last game_state change, score
// conversion completing SCORE_W cycles after it starts) predicts codes/bcd_busy
// every cycle; directed literal checks pin the model to hand-computed values.
`timescale 1ns/1ps
module tb_hex_message_scroller;
  localparam int DIV = 4;
  localparam int SW  = 10;
`ifdef SCORE_TAIL_EN
  localparam int TAIL = 4;
`else
  localparam int TAIL = 0;
`endif
  localparam logic [29:0] BLANK6 = {6{5'h1E}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hex_message_scroller_if #(.SCORE_W(SW)) bus();
  hex_message_scroller #(.SCROLL_DIV(DIV), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int text_len(input int gs);
    case (gs)
      1: return 5;
      2: return 4;
      3: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic logic [4:0] text_at(input int gs, input int t);
    case (gs)
      1: case (t) 0: return 5'h0C; 1: return 5'h13; 2: return 5'h0E; 3: return 5'h0A;
                  default: return 5'h19; endcase
      2: case (t) 0: return 5'h13; 1: return 5'h16; 2: return 5'h1A; default: return 5'h0E; endcase
      default: case (t) 0: return 5'h10; 1: return 5'h0A; 2: return 5'h14; 3: return 5'h0E;
                        4: return 5'h16; 5: return 5'h1D; 6: return 5'h0E; default: return 5'h19; endcase
    endcase
  endfunction

  function automatic logic [4:0] banner_at(input int gs, input int i, input logic [3:0] h,
                                           input logic [3:0] t, input logic [3:0] o);
    int j;
    if (i < 6) return 5'h1E;
    j = i - 6;
    if (j < text_len(gs)) return text_at(gs, j);
    j = j - text_len(gs);
    if (j == 0) return 5'h1F;
    if (j == 1) return {1'b0, h};
    if (j == 2) return {1'b0, t};
    return {1'b0, o};
  endfunction

  function automatic logic [29:0] display(input int gs, input int n, input logic [2:0] lv,
                                          input logic [3:0] h, input logic [3:0] t,
                                          input logic [3:0] o);
    logic [29:0] r;
    int len, p;
    if (gs == 0) return {2'b00, lv, 5'h1F, 5'h1E, 1'b0, h, 1'b0, t, 1'b0, o};
    len = 6 + text_len(gs) + TAIL;
    p = (n / DIV) % len;
    r = 30'd0;
    for (int k = 0; k < 6; k++) r = {r[24:0], banner_at(gs, (p + k) % len, h, t, o)};
    return r;
  endfunction

  int          m_gs = 0, m_n = 0, m_latched = 0, m_cnt = 0, sat;
  logic [3:0]  m_h = 4'd0, m_t = 4'd0, m_o = 4'd0;
  logic [29:0] exp_codes = BLANK6;
  logic        exp_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_gs = 0; m_n = 0; m_latched = 0; m_cnt = 0;
        m_h = 4'd0; m_t = 4'd0; m_o = 4'd0;
        exp_codes = BLANK6; exp_busy = 1'b0;
      end else begin
        exp_codes = display(m_gs, m_n, bus.lives, m_h, m_t, m_o);
        if (int'(bus.game_state) != m_gs) begin
          m_gs = int'(bus.game_state); m_n = 0;
        end else if (m_gs != 0) begin
          m_n++;
        end
        sat = (int'(bus.score) > 999) ? 999 : int'(bus.score);
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_h = 4'((m_latched / 100) % 10);
            m_t = 4'((m_latched / 10) % 10);
            m_o = 4'(m_latched % 10);
          end
        end else if (sat != m_latched) begin
          m_latched = sat;
          m_cnt = SW;
        end
        exp_busy = (m_cnt > 0);
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("codes_model", {2'b00, bus.codes}, {2'b00, exp_codes});
      check("busy_model", {31'd0, bus.bcd_busy}, {31'd0, exp_busy});
    end
  end

  // ---------------- directed stimulus ----------------
  int busy_cnt;
  initial begin
    bus.game_state = 2'b00;
    bus.lives = 3'd3;
    bus.score = 10'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_codes", {2'b00, bus.codes}, {2'b00, BLANK6});
    check("reset_busy", {31'd0, bus.bcd_busy}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("play_after_reset", {2'b00, bus.codes}, {2'b00, 5'h03, 5'h1F, 5'h1E, 15'd0});

    // 0 -> 123
    bus.score = 10'd123;
    busy_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.bcd_busy) busy_cnt++;
      if (i == 11) check("score_not_early", {17'd0, bus.codes[14:0]}, 32'd0);
    end
    check("score_123", {17'd0, bus.codes[14:0]}, {17'd0, 5'd1, 5'd2, 5'd3});
    check("busy_len", busy_cnt, 32'd10);

    // saturation
    bus.score = 10'd1023;
    repeat (14) @(negedge clk);
    check("sat_999", {17'd0, bus.codes[14:0]}, {17'd0, 5'd9, 5'd9, 5'd9});

    // two changes during one conversion
    bus.score = 10'd5;
    repeat (3) @(negedge clk);
    bus.score = 10'd42;
    repeat (3) @(negedge clk);
    bus.score = 10'd77;
    repeat (6) @(negedge clk);
    check("double_first", {17'd0, bus.codes[14:0]}, {17'd0, 5'd0, 5'd0, 5'd5});
    repeat (24) @(negedge clk);
    check("double_final", {17'd0, bus.codes[14:0]}, {17'd0, 5'd0, 5'd7, 5'd7});

    // LOSE scroll
    bus.game_state = 2'b10;
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
      if (i == 5) check("lose_blank", {2'b00, bus.codes}, {2'b00, BLANK6});
      if (i == 6) check("lose_step1", {2'b00, bus.codes}, {2'b00, {5{5'h1E}}, 5'h13});
`ifndef SCORE_TAIL_EN
      if (i == 41) check("lose_step9", {2'b00, bus.codes}, {2'b00, 5'h0E, {5{5'h1E}}});
      if (i == 42) check("lose_wrap", {2'b00, bus.codes}, {2'b00, BLANK6});
`endif
    end

    // GAMEOVER, switched to WIN on a prescaler terminal cycle
    bus.game_state = 2'b11;
    repeat (4) @(negedge clk);
    check("go_blank", {2'b00, bus.codes}, {2'b00, BLANK6});
    bus.game_state = 2'b01;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 2) check("win_restart", {2'b00, bus.codes}, {2'b00, BLANK6});
      if (j == 5) check("win_still_blank", {2'b00, bus.codes}, {2'b00, BLANK6});
      if (j == 6) check("win_step1", {2'b00, bus.codes}, {2'b00, {5{5'h1E}}, 5'h0C});
    end

    // back to PLAY with new lives
    bus.game_state = 2'b00;
    bus.lives = 3'd7;
    repeat (3) @(negedge clk);
    check("play_return", {2'b00, bus.codes},
          {2'b00, 5'h07, 5'h1F, 5'h1E, 5'd0, 5'd7, 5'd7});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
